serial_subtractor: RTL and testbench

- Bit-serial, LSB-first A − B subtractor for unsigned operands of WIDTH bits.
- Each cycle processes one bit pair with a full-subtractor cell: two cascaded half-subtractor stages plus a registered borrow.
- Sits directly downstream of the half_subtractor / half_subtractor_d arithmetic cells. It is the sequential consumer that chains their difference/borrow outputs across bits.
- Start/done handshake; one operation in flight at a time.

---
 rtl/serial_subtractor.sv | 152 +++++++++++++++
 tb/tb_serial_subtractor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial, LSB-first unsigned subtractor computing (a - b) mod 2^WIDTH.
//   One bit pair is processed per cycle by a full-subtractor cell built from
//   two cascaded half-subtractor stages, with the borrow carried in a flop.
//   A start/done handshake allows one operation in flight at a time.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request pulse, only honoured in IDLE
//   a          in   minuend, captured on the accepted start edge
//   b          in   subtrahend, captured on the accepted start edge
//   busy       out  high while bits are being shifted
//   done       out  one-cycle pulse when diff/borrow_out are updated
//   diff       out  registered result (a - b) mod 2^WIDTH
//   borrow_out out  final borrow, 1 iff a < b
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Half-subtractor cell: returns {borrow, difference} of x - y.
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    half_sub = {(~x) & y, x ^ y};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, done_q;

  logic [1:0]       hs1_s;
  logic [1:0]       hs2_s;
  logic             d_s;
  logic             bnext_s;

  // Full-subtractor cell on the current LSBs: first stage subtracts the bits,
  // second stage subtracts the incoming borrow from that partial difference.
  always_comb begin
    hs1_s   = half_sub(sa_q[0], sb_q[0]);
    hs2_s   = half_sub(hs1_s[0], brw_q);
    d_s     = hs2_s[0];
    bnext_s = hs1_s[1] | hs2_s[1];
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        // New result bit enters at the MSB; after WIDTH shifts the first
        // (least significant) bit has arrived at bit 0.
        res_d = {d_s, res_q[WIDTH-1:1]};
        brw_d = bnext_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          diff_d  = {d_s, res_q[WIDTH-1:1]};
          bout_d  = bnext_s;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
      // Status flags are registered from the next state so they line up
      // exactly with the state they describe.
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor. A WIDTH=8 instance covers the
//   handshake, latency, ignored starts, operand changes and async reset; a
//   WIDTH=4 instance is run exhaustively back-to-back. Expected results come
//   from plain modular arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic          clk;
  logic          rst_n;

  logic          start8, busy8, done8, bo8;
  logic [W-1:0]  a8, b8, diff8;

  logic          start4, busy4, done4, bo4;
  logic [W4-1:0] a4, b4, diff4;

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One operation on the 8-bit instance, checked cycle by cycle.
  // mode 0: plain; mode 1: operands randomised every cycle after start;
  // mode 2: extra start pulses (a=1,b=2) in SHIFT cycle 3 and in DONE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int mode);
    logic [W-1:0] exp_d;
    logic         exp_b;
    exp_d  = av - bv;
    exp_b  = (av < bv);
    a8     = av;
    b8     = bv;
    start8 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      n_checks++;
      if (busy8 !== (k < W)) begin
        n_fail++;
        $display("FAIL busy k=%0d: got %b expected %b", k, busy8, (k < W));
      end
      n_checks++;
      if (done8 !== (k == W)) begin
        n_fail++;
        $display("FAIL done k=%0d: got %b expected %b", k, done8, (k == W));
      end
      if (k == W) begin
        n_checks++;
        if (diff8 !== exp_d) begin
          n_fail++;
          $display("FAIL diff a=%0d b=%0d: got %0h expected %0h", av, bv, diff8, exp_d);
        end
        n_checks++;
        if (bo8 !== exp_b) begin
          n_fail++;
          $display("FAIL borrow a=%0d b=%0d: got %b expected %b", av, bv, bo8, exp_b);
        end
      end
      start8 = 1'b0;
      if (mode == 1) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      if (mode == 2 && k == 2) begin
        start8 = 1'b1;
        a8     = 8'd1;
        b8     = 8'd2;
      end
      if (mode == 2 && k == W) begin
        start8 = 1'b1;
      end
    end
    // Result must hold in IDLE and no further done may appear.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_flags: got busy=%b done=%b expected 0 0", busy8, done8);
      end
      n_checks++;
      if (diff8 !== exp_d || bo8 !== exp_b) begin
        n_fail++;
        $display("FAIL hold: got %0h/%b expected %0h/%b", diff8, bo8, exp_d, exp_b);
      end
      if (mode == 1) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset8: got %0h expected 0", {busy8, done8, diff8, bo8});
    end
    n_checks++;
    if ({busy4, done4, diff4, bo4} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset4: got %0h expected 0", {busy4, done4, diff4, bo4});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(8'd5, 8'd3, 0);
    run_op(8'd3, 8'd5, 0);
  endtask

  task automatic test_boundaries();
    run_op(8'd0,   8'd1,   0);
    run_op(8'hFF,  8'hFF,  0);
    run_op(8'd0,   8'd0,   0);
    run_op(8'hFF,  8'd0,   0);
    run_op(8'h80,  8'h7F,  0);
  endtask

  task automatic test_ignored_start();
    run_op(8'd200, 8'd55, 2);
    run_op(8'd1,   8'd2,  0);
  endtask

  task automatic test_operand_change();
    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom), 8'($urandom), 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), 0);
    end
  endtask

  task automatic test_async_reset();
    run_op(8'd9, 8'd4, 0);
    a8 = 8'd77; b8 = 8'd20; start8 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    // SHIFT cycle 4: assert reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, diff8, bo8} !== 11'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %0h expected 0", {busy8, done8, diff8, bo8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset k=%0d: got busy=%b done=%b expected 0 0", k, busy8, done8);
      end
    end
    run_op(8'd100, 8'd150, 0);
  endtask

  // All 256 pairs on the 4-bit instance with start held high, so each
  // operation is accepted at the earliest possible IDLE edge.
  task automatic test_back_to_back();
    int idx;
    int dones;
    int cyc;
    int last;
    int ai;
    int bi;
    logic [W4-1:0] exp_d;
    logic          exp_b;
    idx = 0; dones = 0; cyc = 0; last = -1;
    a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
    while (idx < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (done4 === 1'b1) begin
        ai    = idx / 16;
        bi    = idx % 16;
        exp_d = 4'((ai - bi) & 15);
        exp_b = (ai < bi);
        n_checks++;
        if (diff4 !== exp_d || bo4 !== exp_b || busy4 !== 1'b0) begin
          n_fail++;
          $display("FAIL w4 a=%0d b=%0d: got %0h/%b busy=%b expected %0h/%b busy=0",
                   ai, bi, diff4, bo4, busy4, exp_d, exp_b);
        end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== W4 + 2) begin
            n_fail++;
            $display("FAIL w4_spacing: got %0d expected %0d", cyc - last, W4 + 2);
          end
        end
        last = cyc;
        dones++;
        idx++;
        if (idx < 256) begin
          a4 = 4'(idx / 16);
          b4 = 4'(idx % 16);
        end
      end
    end
    start4 = 1'b0;
    n_checks++;
    if (dones !== 256) begin
      n_fail++;
      $display("FAIL w4_done_count: got %0d expected 256", dones);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_ignored_start();
    test_operand_change();
    test_random();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
